// File: rtl/ab_arb_pkg.sv
// Shared types and the tie-break rule for the two-requester mutex arbiter.
package ab_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    GAP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  // On a tie the side that did not own the resource last goes first.
  function automatic arb_state_t arbitrate(input logic req_a, input logic req_b,
                                           input owner_t last_owner);
    arb_state_t pick;
    if (req_a && req_b) pick = (last_owner == OWN_A) ? GRANT_B : GRANT_A;
    else if (req_a)     pick = GRANT_A;
    else if (req_b)     pick = GRANT_B;
    else                pick = IDLE;
    return pick;
  endfunction

endpackage

// File: rtl/ab_hold_timer.sv
// Loadable saturating down-counter; expired is high while the count sits at zero.
module ab_hold_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ab_mutex_arbiter.sv
// Two-requester round-robin arbiter with bounded hold and a dead gap between owners.
//   state   | meaning
//   IDLE    | no owner, arbitrating every edge
//   GRANT_A | signal_a high, hold timer running
//   GRANT_B | signal_b high, hold timer running
//   GAP     | both grants low for GAP_CYCLES, arbitrates on its final edge
module ab_mutex_arbiter
  import ab_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_a,
  input  logic req_b,
  output logic signal_a,
  output logic signal_b,
  output logic busy,
  output logic timeout_a,
  output logic timeout_b
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t state, state_nxt;
  owner_t     last_owner, owner_nxt;
  logic       hold_load, hold_dec, hold_zero;
  logic       gap_load, gap_dec, gap_zero;
  logic       to_a, to_b;

  always_comb begin
    state_nxt = state;
    owner_nxt = last_owner;
    to_a      = 1'b0;
    to_b      = 1'b0;
    case (state)
      IDLE: state_nxt = arbitrate(req_a, req_b, last_owner);
      GRANT_A: begin
        if (!req_a || hold_zero) begin
          state_nxt = GAP;
          owner_nxt = OWN_A;
          to_a      = req_a && hold_zero;
        end
      end
      GRANT_B: begin
        if (!req_b || hold_zero) begin
          state_nxt = GAP;
          owner_nxt = OWN_B;
          to_b      = req_b && hold_zero;
        end
      end
      GAP: if (gap_zero) state_nxt = arbitrate(req_a, req_b, last_owner);
      default: state_nxt = IDLE;
    endcase
  end

  // Grants never follow each other directly, so any change into a grant is a fresh one.
  assign hold_load = (state_nxt == GRANT_A || state_nxt == GRANT_B) && (state_nxt != state);
  assign hold_dec  = (state == GRANT_A) || (state == GRANT_B);
  assign gap_load  = (state_nxt == GAP) && (state != GAP);
  assign gap_dec   = (state == GAP);

  ab_hold_timer #(.WIDTH(HOLD_W)) u_hold_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (hold_load),
    .load_val (HOLD_W'(MAX_HOLD - 1)),
    .dec      (hold_dec),
    .expired  (hold_zero)
  );

  ab_hold_timer #(.WIDTH(4)) u_gap_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (gap_load),
    .load_val (4'(GAP_CYCLES - 1)),
    .dec      (gap_dec),
    .expired  (gap_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= OWN_B;
      signal_a   <= 1'b0;
      signal_b   <= 1'b0;
      busy       <= 1'b0;
      timeout_a  <= 1'b0;
      timeout_b  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= owner_nxt;
      signal_a   <= (state_nxt == GRANT_A);
      signal_b   <= (state_nxt == GRANT_B);
      busy       <= (state_nxt != IDLE);
      timeout_a  <= to_a;
      timeout_b  <= to_b;
    end
  end

endmodule
